// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: default byte width and the
// arbiter state encoding.
package uart_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit after rr_ptr,
// searching upward with wrap-around.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int GID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GID_W-1:0]   rr_ptr,
  output logic [GID_W-1:0]   winner,
  output logic               any_req
);

  logic [GID_W-1:0] idx;

  // Walk from the farthest candidate back to the nearest so the closest
  // request after rr_ptr is the last one written.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = GID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte sources; each
// frame must finish (tx_busy falls) before the next grant.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ       = 4,
  parameter  int DATA_W        = DATA_W_DEF,
  parameter  int START_TIMEOUT = 16,
  localparam int GID_W         = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [GID_W-1:0]          grant_id,
  output logic                      arb_busy,
  output logic                      err_timeout
);

  localparam int CNT_W = $clog2(START_TIMEOUT);

  arb_state_e          state, state_n;
  logic [GID_W-1:0]    rr_ptr, rr_ptr_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [GID_W-1:0]    grant_id_n;
  logic [DATA_W-1:0]   tx_data_n;
  logic [NUM_REQ-1:0]  req_ready_n;
  logic                tx_start_n;
  logic [GID_W-1:0]    winner;
  logic                any_req;
  logic [DATA_W-1:0]   lane [NUM_REQ];

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req     (req_valid),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) lane[i] = req_data[i*DATA_W +: DATA_W];
  end

  // NOTE: combinational logic uses blocking '=' and assigns every output a
  // default first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    state_n     = state;
    rr_ptr_n    = rr_ptr;
    cnt_n       = cnt;
    grant_id_n  = grant_id;
    tx_data_n   = tx_data;
    req_ready_n = '0;
    tx_start_n  = 1'b0;
    err_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (any_req && !tx_busy) begin
          grant_id_n  = winner;
          tx_data_n   = lane[winner];
          req_ready_n = NUM_REQ'(1) << winner;
          tx_start_n  = 1'b1;
          state_n     = GRANT;
        end
      end
      GRANT: begin
        rr_ptr_n = grant_id;
        cnt_n    = '0;
        state_n  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // A busy edge on the terminal-count cycle still counts as a start.
        if (tx_busy) begin
          state_n = WAIT_DONE;
        end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
          err_timeout = 1'b1;
          state_n     = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking '<=' so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= GID_W'(NUM_REQ - 1);
      cnt       <= '0;
      grant_id  <= '0;
      tx_data   <= '0;
      req_ready <= '0;
      tx_start  <= 1'b0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      cnt       <= cnt_n;
      grant_id  <= grant_id_n;
      tx_data   <= tx_data_n;
      req_ready <= req_ready_n;
      tx_start  <= tx_start_n;
    end
  end

  assign arb_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed requests push expected grants,
// a negedge monitor pops and compares whenever a grant is presented.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        arb_busy;
  logic        err_timeout;

  logic [7:0]  lane [4];
  logic        force_busy;
  logic        model_en;
  int          mcnt  = 0;
  int          cyc   = 0;
  int          tests = 0;
  int          fails = 0;

  typedef struct {
    logic [1:0] gid;
    logic [7:0] data;
    logic [3:0] ready;
  } exp_t;
  exp_t sb [$];

  uart_tx_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .arb_busy    (arb_busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign req_data = {lane[3], lane[2], lane[1], lane[0]};

  // uart_tx stand-in: busy for 10 cycles starting the cycle after tx_start.
  always @(posedge clk) begin
    if (rst) mcnt <= 0;
    else if (tx_start && model_en) mcnt <= 10;
    else if (mcnt != 0) mcnt <= mcnt - 1;
  end
  assign tx_busy = (mcnt != 0) || force_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && (tx_start || req_ready != 4'b0000)) begin
      if (sb.size() == 0) begin
        check("unexpected_grant", {28'd0, req_ready}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("grant_id",  32'(grant_id),  32'(e.gid));
        check("tx_data",   32'(tx_data),   32'(e.data));
        check("req_ready", 32'(req_ready), 32'(e.ready));
        check("tx_start",  32'(tx_start),  32'd1);
      end
    end
  end

  task automatic expect_grant(input logic [1:0] gid);
    sb.push_back('{gid: gid, data: lane[gid], ready: 4'b0001 << gid});
  endtask

  task automatic wait_ready(input string name, output int g);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == 4'b0000 && n < 64);
    check(name, 32'(req_ready != 4'b0000), 32'd1);
    g = cyc;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (arb_busy && n < 64);
    check(name, 32'(arb_busy), 32'd0);
  endtask

  task automatic wait_until(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic issue(input logic [3:0] mask, input logic [1:0] gid, output int g);
    expect_grant(gid);
    @(posedge clk); #1;
    req_valid = mask;
    wait_ready("grant_seen", g);
    @(posedge clk); #1;
    req_valid = 4'b0000;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},   32'(req_ready),   32'd0);
    check({tag, "_tx_start"},    32'(tx_start),    32'd0);
    check({tag, "_tx_data"},     32'(tx_data),     32'd0);
    check({tag, "_grant_id"},    32'(grant_id),    32'd0);
    check({tag, "_arb_busy"},    32'(arb_busy),    32'd0);
    check({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    int g, prev, n0, b, n;
    rst = 1'b1;
    req_valid = 4'b0000;
    force_busy = 1'b0;
    model_en = 1'b1;
    for (int i = 0; i < 4; i++) lane[i] = 8'h10 + 8'(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Contention: all four held valid, grants rotate 0,1,2,3,0,1.
    for (int k = 0; k < 6; k++) expect_grant(2'(k % 4));
    @(posedge clk); #1;
    req_valid = 4'b1111;
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      wait_ready("contention_grant", g);
      if (k > 0) check("contention_gap", 32'(g - prev), 32'd13);
      prev = g;
    end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    wait_idle("contention_idle");

    // Single request: one-cycle latency, arb_busy falls one cycle after busy.
    lane[2] = 8'hA5;
    expect_grant(2'd2);
    @(posedge clk); #1;
    req_valid = 4'b0100;
    @(negedge clk);
    n0 = cyc;
    check("single_no_early_ready", 32'(req_ready), 32'd0);
    wait_ready("single_grant", g);
    check("single_latency", 32'(g - n0), 32'd1);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    wait_until(g + 10);
    check("single_busy_last", 32'(tx_busy), 32'd1);
    wait_until(g + 11);
    check("single_still_busy", 32'(arb_busy), 32'd1);
    wait_until(g + 12);
    check("single_arb_idle", 32'(arb_busy), 32'd0);
    lane[2] = 8'h12;

    // Pointer fairness: grant 3, then 1001 -> 0, then 1001 -> 3.
    issue(4'b1000, 2'd3, g);
    wait_idle("fair_idle_a");
    issue(4'b1001, 2'd0, g);
    wait_idle("fair_idle_b");
    issue(4'b1001, 2'd3, g);
    wait_idle("fair_idle_c");

    // Timeout: no busy response, error exactly START_TIMEOUT after tx_start.
    model_en = 1'b0;
    issue(4'b0010, 2'd1, g);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!err_timeout && n < 40);
    check("timeout_seen", 32'(err_timeout), 32'd1);
    check("timeout_latency", 32'(cyc - g), 32'd16);
    @(negedge clk);
    check("timeout_pulse_width", 32'(err_timeout), 32'd0);
    check("timeout_back_idle", 32'(arb_busy), 32'd0);
    model_en = 1'b1;
    lane[2] = 8'h5A;
    issue(4'b0100, 2'd2, g);
    wait_idle("after_timeout_idle");
    lane[2] = 8'h12;

    // Busy rising on the terminal-count cycle is a successful start.
    model_en = 1'b0;
    issue(4'b0001, 2'd0, g);
    do begin
      @(posedge clk); #1;
    end while (cyc < g + 16);
    force_busy = 1'b1;
    @(negedge clk);
    check("race_no_err", 32'(err_timeout), 32'd0);
    @(negedge clk);
    check("race_wait_done", 32'(arb_busy), 32'd1);
    check("race_no_err_late", 32'(err_timeout), 32'd0);
    @(posedge clk); #1;
    force_busy = 1'b0;
    model_en = 1'b1;
    wait_idle("race_idle");

    // Busy-blocked: no grant while tx_busy is high in IDLE.
    @(posedge clk); #1;
    force_busy = 1'b1;
    expect_grant(2'd0);
    req_valid = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("blocked_no_ready", 32'(req_ready), 32'd0);
    end
    check("blocked_arb_idle", 32'(arb_busy), 32'd0);
    @(posedge clk); #1;
    force_busy = 1'b0;
    b = cyc;
    wait_ready("blocked_grant", g);
    check("blocked_latency", 32'(g - b), 32'd1);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    wait_idle("blocked_idle");

    // Reset during WAIT_DONE; pointer returns so 0011 grants 0, not 1.
    issue(4'b0001, 2'd0, g);
    wait_until(g + 4);
    check("pre_reset_busy", 32'(arb_busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    wait_until(g + 6);
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_no_replay", 32'(req_ready), 32'd0);
    issue(4'b0011, 2'd0, g);
    wait_idle("post_reset_idle");

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
